id_ex_stage: RTL

ID/EX pipeline stage of the MIPS pipeline, directly downstream of the register file. Captures the two operands read in ID, the decoded control bundle and the instruction fields, and presents them registered to EX. Owns load-use hazard detection: inserts a bubble and asserts `stall` upstream. Also applies a same-cycle WB bypass, flush on taken branch/jump, and a hold for downstream freezes.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/id_ex_stage_hazard_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared types and constants for the MIPS pipeline.
//   alu_op_t : ALU operation selector carried in the control bundle.
//   ctrl_t   : decoded control bundle passed from ID through the pipeline.
//   idex_t   : full ID/EX pipeline register payload.
//   REG_ZERO : architectural register $0 (hardwired to zero).
//   is_bypass: true when a WB write targets a given non-zero source register.
package mips_pkg;

  localparam int          DATA_W   = 32;
  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5,
    ALU_XOR = 3'd6,
    ALU_SLL = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_t alu_op;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    ctrl_t             ctrl;
  } idex_t;

  // $0 is never a bypass target: its read value is constant zero.
  function automatic logic is_bypass(
    input logic             wr_en,
    input logic [REG_W-1:0] wr_addr,
    input logic [REG_W-1:0] rd_addr
  );
    return wr_en && (wr_addr != REG_ZERO) && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect
// Combinational load-use hazard detector. Flags the case where the
// instruction in EX is a load whose destination (rt) is a source of the
// instruction currently in ID.
//   id_valid, id_rs, id_rt, id_uses_rt : ID-side instruction fields
//   ex_valid, ex_mem_read, ex_rt       : registered EX-side fields
//   lu_hazard                          : one-bubble load-use hazard
module hazard_detect
  import mips_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu_hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match  = (ex_rt == id_rs);
  // rt only matters for instructions that actually read it as a source.
  assign rt_match  = id_uses_rt && (ex_rt == id_rt);
  // A load into $0 produces nothing to wait for.
  assign lu_hazard = id_valid && ex_valid && ex_mem_read &&
                     (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register. Captures operands, immediate, PC+4, register
// fields and the control bundle from ID and presents them to EX one cycle
// later. Detects load-use hazards (bubble + upstream stall), applies a
// same-cycle WB bypass on the operands, squashes on flush and freezes on hold.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decoded instruction from IF/ID and register file
//   wb_*              : write-back port, used for same-cycle bypass
//   flush             : squash the ID instruction (taken branch/jump)
//   hold              : EX frozen, keep ID/EX contents
//   stall             : freeze PC and IF/ID this cycle
//   ex_*              : registered outputs towards EX
//   bubble_cnt        : saturating count of load-use bubbles
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs,
  input  logic [4:0]              id_rt,
  input  logic [4:0]              id_rd,
  input  logic [31:0]             id_rs_data,
  input  logic [31:0]             id_rt_data,
  input  logic [31:0]             id_imm,
  input  logic [31:0]             id_pc4,
  input  logic                    id_uses_rt,
  input  ctrl_t                   id_ctrl,
  input  logic                    wb_reg_write,
  input  logic [4:0]              wb_addr,
  input  logic [31:0]             wb_data,
  input  logic                    flush,
  input  logic                    hold,
  output logic                    stall,
  output logic                    ex_valid,
  output logic [4:0]              ex_rs,
  output logic [4:0]              ex_rt,
  output logic [4:0]              ex_rd,
  output logic [31:0]             ex_rs_data,
  output logic [31:0]             ex_rt_data,
  output logic [31:0]             ex_imm,
  output logic [31:0]             ex_pc4,
  output ctrl_t                   ex_ctrl,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = {BUBBLE_CNT_W{1'b1}};
  localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

  idex_t                   payload_reg;
  idex_t                   payload_next;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_reg;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_next;
  logic                    lu_hazard;

  // ---------------------------------------------------------------------
  // Hazard detection against the registered EX slot.
  // ---------------------------------------------------------------------
  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_valid    (payload_reg.valid),
    .ex_mem_read (payload_reg.ctrl.mem_read),
    .ex_rt       (payload_reg.rt),
    .lu_hazard   (lu_hazard)
  );

  // Flush wins over both hazard and hold: the ID instruction is discarded,
  // so there is nothing to keep upstream. Reset also releases the stall so
  // the front end restarts cleanly.
  assign stall = ~rst & (lu_hazard | hold) & ~flush;

  // ---------------------------------------------------------------------
  // WB bypass muxes, one per source operand (index 0 = rs, 1 = rt).
  // ---------------------------------------------------------------------
  logic [4:0]  src_addr [2];
  logic [31:0] src_rf   [2];
  logic [31:0] src_val  [2];

  assign src_addr[0] = id_rs;
  assign src_addr[1] = id_rt;
  assign src_rf[0]   = id_rs_data;
  assign src_rf[1]   = id_rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bypass
      assign src_val[gi] = is_bypass(wb_reg_write, wb_addr, src_addr[gi])
                           ? wb_data : src_rf[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Next-state selection: flush > hold > load-use bubble > load.
  // ---------------------------------------------------------------------
  always_comb begin
    payload_next    = payload_reg;
    bubble_cnt_next = bubble_cnt_reg;
    if (flush) begin
      payload_next = '0;
    end else if (hold) begin
      payload_next = payload_reg;
    end else if (lu_hazard) begin
      // Fully zeroed bubble keeps EX deterministic.
      payload_next = '0;
      if (bubble_cnt_reg != CNT_MAX) begin
        bubble_cnt_next = bubble_cnt_reg + CNT_ONE;
      end
    end else begin
      payload_next.valid   = id_valid;
      payload_next.rs      = id_rs;
      payload_next.rt      = id_rt;
      payload_next.rd      = id_rd;
      payload_next.rs_data = src_val[0];
      payload_next.rt_data = src_val[1];
      payload_next.imm     = id_imm;
      payload_next.pc4     = id_pc4;
      // Fields of an empty slot are still captured, but its control must
      // never cause side effects downstream.
      payload_next.ctrl    = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload_reg    <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      payload_reg    <= payload_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Output mapping.
  // ---------------------------------------------------------------------
  assign ex_valid   = payload_reg.valid;
  assign ex_rs      = payload_reg.rs;
  assign ex_rt      = payload_reg.rt;
  assign ex_rd      = payload_reg.rd;
  assign ex_rs_data = payload_reg.rs_data;
  assign ex_rt_data = payload_reg.rt_data;
  assign ex_imm     = payload_reg.imm;
  assign ex_pc4     = payload_reg.pc4;
  assign ex_ctrl    = payload_reg.ctrl;
  assign bubble_cnt = bubble_cnt_reg;

endmodule
